// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 memory stage: access-size encodings,
// FSM state type and byte-enable width.
package riscv_mem_pkg;

    localparam int unsigned BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_R
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational load/store lane handling: misalignment detection, byte enables,
// lane-replicated store data and load extraction with sign/zero extension.
module load_store_align
    import riscv_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic [1:0]      lane_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic            misaligned_o,
    output logic [BE_W-1:0] be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] rdata_fmt_o
);

    logic       is_byte;
    logic       is_half;
    logic       is_uns;
    logic [1:0] lane_eff;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;

    // Anything that is not a byte or half encoding is handled as a word access.
    assign is_byte = (funct3_i == F3_B) || (funct3_i == F3_BU);
    assign is_half = (funct3_i == F3_H) || (funct3_i == F3_HU);
    assign is_uns  = funct3_i[2];

    assign misaligned_o = ALIGN_CHECK &&
                          ((is_half && lane_i[0]) ||
                           (!is_byte && !is_half && (lane_i != 2'b00)));

    // Force-align: lanes below the access size are cleared.
    assign lane_eff = is_byte ? lane_i :
                      is_half ? {lane_i[1], 1'b0} : 2'b00;

    assign ld_byte = rdata_i[{lane_eff, 3'b000} +: 8];
    assign ld_half = rdata_i[{lane_eff[1], 4'b0000} +: 16];

    always_comb begin
        be_o        = '0;
        wdata_o     = '0;
        rdata_fmt_o = '0;
        if (is_byte) begin
            be_o        = BE_W'(1) << lane_eff;
            wdata_o     = {4{store_data_i[7:0]}};
            rdata_fmt_o = is_uns ? {{(XLEN-8){1'b0}}, ld_byte}
                                 : {{(XLEN-8){ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            be_o        = lane_eff[1] ? 4'b1100 : 4'b0011;
            wdata_o     = {2{store_data_i[15:0]}};
            rdata_fmt_o = is_uns ? {{(XLEN-16){1'b0}}, ld_half}
                                 : {{(XLEN-16){ld_half[15]}}, ld_half};
        end else begin
            be_o        = '1;
            wdata_o     = store_data_i;
            rdata_fmt_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// RV32 memory stage: drives a req/gnt/rvalid data memory, stalls upstream while
// an access is outstanding and registers the MEM/WB boundary.
module mem_stage_pipe
    import riscv_mem_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned REGADDR_W   = 5,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [XLEN-1:0]      ex_alu_out,
    input  logic [XLEN-1:0]      ex_store_data,
    input  logic [2:0]           ex_funct3,
    input  logic                 ex_mem_read,
    input  logic                 ex_mem_write,
    input  logic                 ex_reg_write,
    input  logic [REGADDR_W-1:0] ex_wr_addr,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [BE_W-1:0]      mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 stall_o,
    output logic                 fwd_reg_write,
    output logic [REGADDR_W-1:0] fwd_wr_addr,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [REGADDR_W-1:0] wb_wr_addr,
    output logic [XLEN-1:0]      wb_data,
    output logic                 wb_misaligned
);

    if (XLEN != 32) begin : g_xlen_check
        $error("mem_stage_pipe: XLEN must be 32");
    end

    mem_state_e             state_q, state_d;
    logic                   wb_valid_q, wb_reg_write_q, wb_misaligned_q;
    logic [REGADDR_W-1:0]   wb_wr_addr_q;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;
    logic                   is_mem;
    logic                   mis_raw;
    logic                   misaligned;
    logic                   complete;
    logic                   load_done;
    logic [XLEN-1:0]        rdata_fmt;

    load_store_align #(
        .XLEN        (XLEN),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_align (
        .lane_i       (ex_alu_out[1:0]),
        .funct3_i     (ex_funct3),
        .store_data_i (ex_store_data),
        .rdata_i      (mem_rdata),
        .misaligned_o (mis_raw),
        .be_o         (mem_be),
        .wdata_o      (mem_wdata),
        .rdata_fmt_o  (rdata_fmt)
    );

    assign is_mem     = ex_mem_read | ex_mem_write;
    assign misaligned = is_mem & mis_raw;
    assign mem_addr   = ADDR_W'(ex_alu_out) & ~ADDR_W'(3);
    assign mem_we     = ex_mem_write;

    // Access sequencing; rvalid is only honoured while a load is outstanding.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        complete  = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (!is_mem || misaligned) begin
                        complete = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        if (mem_gnt) begin
                            if (ex_mem_write) complete = 1'b1;
                            else              state_d  = ST_WAIT_R;
                        end
                    end
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid) begin
                    complete  = 1'b1;
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stall_o   = ex_valid & ~complete;
    assign wb_data_d = load_done ? rdata_fmt : ex_alu_out;

    assign fwd_reg_write = ex_valid & ex_reg_write & ~ex_mem_read;
    assign fwd_wr_addr   = ex_wr_addr;
    assign fwd_data      = ex_alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_misaligned_q <= 1'b0;
            wb_wr_addr_q    <= '0;
            wb_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            wb_valid_q      <= complete;
            wb_reg_write_q  <= complete & ex_reg_write & ~misaligned;
            wb_misaligned_q <= complete & misaligned;
            if (complete) begin
                wb_wr_addr_q <= ex_wr_addr;
                wb_data_q    <= wb_data_d;
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_wr_addr    = wb_wr_addr_q;
    assign wb_data       = wb_data_q;
    assign wb_misaligned = wb_misaligned_q;

endmodule
